// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the checksum residue that marks a valid image.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CHECK   = 3'd2,
    RELEASE = 3'd3,
    ERROR   = 3'd4
  } state_t;

  localparam logic [15:0] CKSUM_OK = 16'h0000;

endpackage

// File: rtl/imem_wr_reg.sv
// Registered instruction-memory write port: owns the running write address
// and presents one write per accepted stream word, a cycle after acceptance.
module imem_wr_reg
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata
);

  logic [ADDR_W-1:0] addr;

  // The address counter wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr     <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
    end else begin
      im_we <= wr;
      if (load) begin
        addr <= base_addr;
      end else if (wr) begin
        addr     <= addr + ADDR_W'(1);
        im_addr  <= addr;
        im_wdata <= wdata;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a program image into instruction memory while holding fetch,
// validates the trailing checksum and then pulses a CPU restart.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state, state_next;
  logic [15:0]       remaining;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] chk_sum;
  logic              xfer;
  logic              wr;
  logic              accept_start;

  assign in_ready  = (state == LOAD) || (state == CHECK);
  assign xfer      = in_valid && in_ready;
  assign wr        = xfer && (state == LOAD);
  assign chk_sum   = sum + in_data;
  assign cpu_hold  = (state != IDLE);
  assign busy      = (state != IDLE);
  assign cpu_rst_n = (state != RELEASE);

  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    case (state)
      IDLE, ERROR: begin
        if (start) begin
          accept_start = 1'b1;
          state_next   = (word_count != 16'd0) ? LOAD : CHECK;
        end
      end
      LOAD: begin
        if (xfer && remaining == 16'd1) state_next = CHECK;
      end
      CHECK: begin
        if (xfer) state_next = (chk_sum == DATA_W'(CKSUM_OK)) ? RELEASE : ERROR;
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // done marks the first IDLE cycle after the restart pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      sum       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == RELEASE);
      if (accept_start) begin
        remaining <= word_count;
        sum       <= '0;
        err       <= 1'b0;
      end else if (wr) begin
        remaining <= remaining - 16'd1;
        sum       <= chk_sum;
      end
      if (state == CHECK && xfer && chk_sum != DATA_W'(CKSUM_OK)) err <= 1'b1;
    end
  end

  imem_wr_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_wr_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept_start),
    .base_addr(base_addr),
    .wr       (wr),
    .wdata    (in_data),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata)
  );

endmodule
